// File: rtl/mips_div_unit.sv
// Iterative restoring divider with architectural HI/LO for DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
// Define DIV_SIGNED_EN to honour is_signed; otherwise every divide is unsigned.
module mips_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] dvd_raw_q;
  logic            dz_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic            busy_q;
  logic            done_q;
  logic            dbz_q;

  logic [XLEN:0]   rem_sh;
  logic            take;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;

  logic [XLEN-1:0] dvd_abs;
  logic [XLEN-1:0] dvs_abs;
  logic [XLEN-1:0] lo_fix;
  logic [XLEN-1:0] hi_fix;

`ifdef DIV_SIGNED_EN
  logic neg_q_q;
  logic neg_r_q;
  logic neg_q_d;
  logic neg_r_d;

  // Magnitudes of the operands and result signs for a signed divide.
  always_comb begin
    neg_r_d = is_signed & dividend[XLEN-1];
    neg_q_d = neg_r_d ^ (is_signed & divisor[XLEN-1]);
    dvd_abs = neg_r_d ? -dividend : dividend;
    dvs_abs = (is_signed & divisor[XLEN-1]) ? -divisor : divisor;
  end

  // Restore signs: quotient by sign mismatch, remainder follows dividend.
  always_comb begin
    lo_fix = neg_q_q ? -quo_q : quo_q;
    hi_fix = neg_r_q ? -rem_q : rem_q;
  end
`else
  logic unused_sign;

  // Unsigned-only build: operands pass through untouched.
  always_comb begin
    unused_sign = is_signed;
    dvd_abs     = dividend;
    dvs_abs     = divisor;
    lo_fix      = quo_q;
    hi_fix      = rem_q;
  end
`endif

  // One restoring step: shift {rem, quo} left, trial-subtract, set quotient bit.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    take   = (rem_sh >= {1'b0, dvs_q});
    rem_d  = take ? XLEN'(rem_sh - {1'b0, dvs_q})
                  : rem_sh[XLEN-1:0];
    quo_d  = {quo_q[XLEN-2:0], take};
  end

  // Control FSM plus all datapath and architectural registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_raw_q <= '0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            rem_q     <= '0;
            quo_q     <= dvd_abs;
            dvs_q     <= dvs_abs;
            dvd_raw_q <= dividend;
            dz_q      <= (divisor == '0);
            dbz_q     <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
`ifdef DIV_SIGNED_EN
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
`endif
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          // Zero divisor bypasses the algorithm result entirely.
          if (dz_q) begin
            lo_q  <= '1;
            hi_q  <= dvd_raw_q;
            dbz_q <= 1'b1;
          end else begin
            lo_q <= lo_fix;
            hi_q <= hi_fix;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
